// File: rtl/lfsr32_gen.sv
// 32-bit Fibonacci LFSR with programmable taps, seed load and all-zero lock-up protection.
// Latency: Q updates on the edge that samples the controls; no backpressure, steps whenever en=1.
module lfsr32_gen #(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   TAPS  = 32'h8020_0003,
    parameter logic [WIDTH-1:0]   SEED  = 32'h0000_0001
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      seed_in,
    output logic [WIDTH-1:0]      Q,
    output logic                  serial_out,
    output logic                  zero_fix
);

    logic [WIDTH-1:0] r_q;
    logic             r_zero_fix;

    logic             w_fb;
    logic [WIDTH-1:0] w_q_step;
    logic             w_load_zero;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_zf_nxt;

    assign w_fb        = ^(r_q & TAPS);
    assign w_q_step    = {r_q[WIDTH-2:0], w_fb};
    assign w_load_zero = (seed_in == '0);

    // Priority load > en > hold; reset is applied in the register process.
    // A zero seed is swapped for SEED so the register can never lock up at zero.
    always_comb begin
        w_q_nxt  = r_q;
        w_zf_nxt = 1'b0;
        if (load) begin
            if (w_load_zero) begin
                w_q_nxt  = SEED;
                w_zf_nxt = 1'b1;
            end else begin
                w_q_nxt  = seed_in;
            end
        end else if (en) begin
            w_q_nxt = w_q_step;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_q        <= SEED;
            r_zero_fix <= 1'b0;
        end else begin
            r_q        <= w_q_nxt;
            r_zero_fix <= w_zf_nxt;
        end
    end

    assign Q          = r_q;
    assign serial_out = r_q[WIDTH-1];
    assign zero_fix   = r_zero_fix;

endmodule

// File: tb/tb_lfsr32_gen.sv
// Bench for lfsr32_gen: directed sequence checks followed by randomized control traffic against a reference model.
module tb_lfsr32_gen;

    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam int          N_RAND = 20000;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en      = 1'b0;
    logic        load    = 1'b0;
    logic [31:0] seed_in = '0;
    logic [31:0] Q;
    logic        serial_out;
    logic        zero_fix;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_q  = '0;
    logic        m_zf = 1'b0;

    always #5 sys_clk = ~sys_clk;

    lfsr32_gen #(
        .WIDTH (32),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .Q          (Q),
        .serial_out (serial_out),
        .zero_fix   (zero_fix)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Multiply by two modulo 2^32, then add the parity of the tapped bits.
    function automatic logic [31:0] model_step(input logic [31:0] q);
        int unsigned ones;
        ones = $countones(q & TAPS);
        return (q << 1) | ((ones % 2 == 1) ? 32'd1 : 32'd0);
    endfunction

    task automatic model_update(input logic r, input logic l, input logic e, input logic [31:0] s);
        if (r) begin
            m_q  = SEED;
            m_zf = 1'b0;
        end else if (l) begin
            m_q  = (s == 32'd0) ? SEED : s;
            m_zf = (s == 32'd0);
        end else begin
            if (e) m_q = model_step(m_q);
            m_zf = 1'b0;
        end
    endtask

    // Drive one cycle of controls, let the edge happen, then compare outputs to the model.
    task automatic cycle(input logic r, input logic l, input logic e, input logic [31:0] s, input string tag);
        sys_rst = r;
        load    = l;
        en      = e;
        seed_in = s;
        @(posedge sys_clk);
        #1;
        model_update(r, l, e, s);
        check_val({tag, ".q"},      Q,                 m_q);
        check_val({tag, ".zf"},     32'(zero_fix),     32'(m_zf));
        check_val({tag, ".serial"}, 32'(serial_out),   32'(m_q[31]));
        check_val({tag, ".nz"},     32'(Q == 32'd0),   32'd0);
    endtask

    // Directed cycle: also compares against values written out by hand.
    task automatic dcyc(input logic r, input logic l, input logic e, input logic [31:0] s,
                        input logic [31:0] exp_q, input logic exp_zf, input string tag);
        cycle(r, l, e, s, tag);
        check_val({tag, ".q_const"},  Q,             exp_q);
        check_val({tag, ".zf_const"}, 32'(zero_fix), 32'(exp_zf));
    endtask

    initial begin
        logic        r, l, e;
        logic [31:0] s;

        dcyc(1, 0, 0, 32'h0,        32'h0000_0001, 0, "rst0");
        dcyc(1, 0, 1, 32'h0,        32'h0000_0001, 0, "rst1");
        dcyc(0, 0, 1, 32'h0,        32'h0000_0003, 0, "seq1");
        dcyc(0, 0, 1, 32'h0,        32'h0000_0006, 0, "seq2");
        dcyc(0, 0, 1, 32'h0,        32'h0000_000D, 0, "seq3");
        dcyc(0, 0, 0, 32'h0,        32'h0000_000D, 0, "hold1");
        dcyc(0, 0, 0, 32'hFFFF_FFFF, 32'h0000_000D, 0, "hold2");
        dcyc(0, 0, 0, 32'h0,        32'h0000_000D, 0, "hold3");
        dcyc(0, 0, 1, 32'h0,        32'h0000_001B, 0, "seq4");
        dcyc(0, 0, 1, 32'h0,        32'h0000_0036, 0, "seq5");
        dcyc(0, 0, 1, 32'h0,        32'h0000_006D, 0, "seq6");
        dcyc(0, 1, 1, 32'h8000_0000, 32'h8000_0000, 0, "load_msb");
        dcyc(0, 0, 1, 32'h0,        32'h0000_0001, 0, "step_msb");
        dcyc(0, 1, 1, 32'h0,        32'h0000_0001, 1, "load_zero");
        dcyc(0, 0, 1, 32'h0,        32'h0000_0003, 0, "after_zero");
        dcyc(1, 1, 1, 32'h1234_5678, 32'h0000_0001, 0, "rst_wins");
        dcyc(0, 1, 0, 32'h0,        32'h0000_0001, 1, "zero_a");
        dcyc(0, 1, 0, 32'h0,        32'h0000_0001, 1, "zero_b");
        dcyc(0, 0, 0, 32'h0,        32'h0000_0001, 0, "zero_end");
        dcyc(0, 1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, "load_val");

        for (int i = 0; i < N_RAND; i++) begin
            r = ($urandom_range(0, 499) == 0);
            l = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            cycle(r, l, e, s, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
